ad669_wr_sequencer: RTL

//  Upstream write sequencer for the AD669 DAC bank (DX/DY/DZ/SET 16-bit, X/Y GAIN/OFFSET 8-bit).

---
 rtl/ad669_wr_sequencer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/ad669_wr_sequencer.sv
// Write sequencer for the AD669 DAC bank: one {channel, data} write per transaction, with timed
// data setup / strobe / hold. Optional macro SYNC_LDAC_EN adds ldac_req/ldac_n second-rank update.
module ad669_wr_sequencer #(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 1,
    parameter int HOLD_CYC  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_req,
    input  logic [2:0]  wr_chan,
    input  logic [15:0] wr_data,
    input  logic        ovr_clr,
`ifdef SYNC_LDAC_EN
    input  logic        ldac_req,
    output logic        ldac_n,
`endif
    output logic        busy,
    output logic        done,
    output logic        ovr,
    output logic [15:0] cpld_sd,
    output logic [7:0]  wr_n,
    output logic [2:0]  state_dbg
);

    // Handshake: wr_req (and ldac_req) are single-cycle pulses honoured only while state is IDLE,
    // which includes the done cycle; a pulse arriving in any other state is dropped and sets ovr.

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_STROBE = 3'd2,
        S_HOLD   = 3'd3,
        S_LDAC   = 3'd4
    } state_t;

    localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       chan_q, chan_n;
    logic [15:0]      sd_n;
    logic [7:0]       wr_n_n;
    logic             busy_n, done_n, ovr_n, ovr_set;
    logic             ldac_go;

`ifdef SYNC_LDAC_EN
    logic ldac_n_n;
    assign ldac_go = ldac_req;
`else
    assign ldac_go = 1'b0;
`endif

    assign state_dbg = state;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        chan_n  = chan_q;
        sd_n    = cpld_sd;
        done_n  = 1'b0;
        ovr_set = 1'b0;

        if (state != S_IDLE && (wr_req || ldac_go)) begin
            ovr_set = 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (wr_req) begin
                    chan_n  = wr_chan;
                    // Gain/offset channels (4-7) are 8-bit parts: upper byte forced to zero.
                    sd_n    = wr_chan[2] ? {8'h00, wr_data[7:0]} : wr_data;
                    state_n = S_SETUP;
                    cnt_n   = '0;
                    if (ldac_go) begin
                        ovr_set = 1'b1;
                    end
                end else if (ldac_go) begin
                    state_n = S_LDAC;
                    cnt_n   = '0;
                end
            end
            S_SETUP: begin
                if (cnt == SETUP_LAST) begin
                    state_n = S_STROBE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_STROBE: begin
                if (cnt == PULSE_LAST) begin
                    state_n = S_HOLD;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (cnt == HOLD_LAST) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                    done_n  = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_LDAC: begin
                if (cnt == PULSE_LAST) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                    done_n  = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase

        // Outputs are registered from the next state so pins change exactly on the edge.
        wr_n_n = 8'hFF;
        if (state_n == S_STROBE) begin
            wr_n_n[chan_n] = 1'b0;
        end
        busy_n = (state_n != S_IDLE);
        // A fresh overrun outranks a clear arriving in the same cycle.
        ovr_n  = ovr_set ? 1'b1 : (ovr_clr ? 1'b0 : ovr);
`ifdef SYNC_LDAC_EN
        ldac_n_n = (state_n != S_LDAC);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            chan_q  <= 3'd0;
            cpld_sd <= 16'h0000;
            wr_n    <= 8'hFF;
            busy    <= 1'b0;
            done    <= 1'b0;
            ovr     <= 1'b0;
`ifdef SYNC_LDAC_EN
            ldac_n  <= 1'b1;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            chan_q  <= chan_n;
            cpld_sd <= sd_n;
            wr_n    <= wr_n_n;
            busy    <= busy_n;
            done    <= done_n;
            ovr     <= ovr_n;
`ifdef SYNC_LDAC_EN
            ldac_n  <= ldac_n_n;
`endif
        end
    end

endmodule
